wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Final (write-back) pipeline stage. Consumes the MEM-to-WB bus and retires one instruction per cycle.
- Performs the byte-enabled register-file write and drives the debug trace ports.
- Hosts the CP0 register subset: Status, Cause, EPC, BadVAddr, Count, Compare.
- Commits exceptions and ERET, producing the flush request and redirect target for all upstream stages.

Parameters:
- EX_ENTRY, 32'hbfc00380, exception vector PC.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- ms_to_ws_valid  in  1  MEM stage holds a valid instruction.
- ms_to_ws_bus  in  155  fields:
  - [154] ex, [153:149] exccode, [148] bd, [147:116] badvaddr
  - [115] eret, [114] mtc0, [113:106] cp0_addr {rd[4:0], sel[2:0]}, [105:74] cp0_wdata
  - [73] res_from_cp0, [72:69] rf_we[3:0], [68:64] dest, [63:32] final_result, [31:0] pc
- ws_allowin  out  1  WB can accept an instruction.
- ws_to_rf_bus  out  41  {rf_we[3:0], rf_waddr[4:0], rf_wdata[31:0]}.
- ws_valid  out  1  registered valid.
- ws_handle_ex  out  1  flush request (exception or ERET retiring).
- ws_ex_target  out  32  redirect PC, meaningful when ws_handle_ex=1.
- ws_int_pending  out  1  enabled interrupt pending, consumed by decode for tagging.
- debug_wb_pc  out  32
- debug_wb_rf_wen  out  4
- debug_wb_rf_wnum  out  5
- debug_wb_rf_wdata  out  32

Behaviour:
- Handshake:
  - ready_go=1; ws_allowin = 1.
  - Bus register loads when ms_to_ws_valid && ws_allowin.
  - ws_valid:
    - 0 on reset.
    - 0 the cycle after ws_handle_ex=1, even if ms_to_ws_valid=1 that cycle; the younger instruction is discarded.
    - Otherwise ws_valid <= ms_to_ws_valid.
- Retire is combinational on the registered bus (0-cycle latency inside WB).
- Register-file write:
  - rf_we = ws_valid && !ex ? bus rf_we : 4'b0.
  - wdata = res_from_cp0 ? cp0_rdata : final_result.
  - Debug ports mirror pc, rf_we (gated), dest and wdata.
- ws_handle_ex = ws_valid && (ex || eret).
- ws_ex_target = eret && !ex ? EPC : EX_ENTRY. ex has priority over eret.
- CP0 read decode (cp0_addr), unlisted addresses read 0:
  - {8,0} BadVAddr
  - {9,0} Count
  - {11,0} Compare
  - {12,0} Status
  - {13,0} Cause
  - {14,0} EPC
- Status:
  - Bit 22 BEV is constant 1.
  - Bits [15:8] IM and [1] EXL, [0] IE are writable.
  - All other bits read 0.
  - Reset: IM=0, EXL=0, IE=0.
- Cause:
  - [31] BD, [30] TI.
  - [15] IP7 = TI.
  - [14:10] read 0.
  - [9:8] IP1..0 writable.
  - [6:2] ExcCode.
  - Reset: all 0.
- Exception commit (ws_valid && ex):
  - EXL <= 1.
  - If EXL was 0: EPC <= bd ? pc-4 : pc, and BD <= bd.
  - If EXL was 1: EPC and BD are unchanged.
  - ExcCode <= exccode.
  - If exccode is 5'h04 or 5'h05: BadVAddr <= badvaddr.
  - Any mtc0 in the same instruction is suppressed.
- ERET commit (ws_valid && eret && !ex): EXL <= 0.
- MTC0 (ws_valid && mtc0 && !ex): writes cp0_wdata to the addressed register's writable fields.
  - Writing EPC, Count or Compare updates the whole register.
  - Compare write also clears TI.
- Count:
  - An internal 1-bit tick toggles every cycle; Count increments (wrapping at 2^32) when tick=1.
  - An MTC0 Count write overrides the increment that cycle.
  - Reset: tick=0, Count=0.
- TI:
  - Set when Count==Compare, evaluated on the current register values (before update) each cycle.
  - Compare write has priority: it clears TI in the same cycle.
- ws_int_pending = IE && !EXL && |(IM & Cause[15:8]).
- Reset values of all outputs are 0, except ws_ex_target = EX_ENTRY and ws_allowin = 1.

Test Plan:
- ALU retire: valid bus with rf_we=4'b1111, dest=5, final_result=32'h1234 -> ws_to_rf_bus={4'hf,5'd5,32'h1234}; debug_wb_pc equals bus pc the same cycle.
- Exception in delay slot: ex=1, exccode=5'h04, bd=1, pc=32'hbfc00104, badvaddr=32'h3 ->
  - ws_handle_ex=1, rf_we=0, target=32'hbfc00380.
  - Next cycle: EPC=32'hbfc00100, BD=1, ExcCode=4, BadVAddr=3, EXL=1, ws_valid=0 despite ms_to_ws_valid=1.
- Nested exception with EXL=1: second exception at pc=32'h100 -> EPC and BD unchanged; ExcCode updated.
- MTC0/MFC0/ERET:
  - mtc0 {14,0} with 32'h80 -> next mfc0 {14,0} returns 32'h80.
  - Then eret -> ws_ex_target=32'h80, EXL cleared next cycle.
- Timer:
  - mtc0 Compare=3, Count=0 -> TI sets once Count reaches 3 (about 6 cycles later).
  - Then Status IM7=1, IE=1 -> ws_int_pending=1.
  - mtc0 Compare clears TI and ws_int_pending.
- Reset mid-operation: assert reset while ws_valid=1 and EXL=1 -> next cycle ws_valid=0, Status=32'h00400000, Count=0, rf_we=0.

Source files
------------

// File: rtl/wb_stage_if.sv
// MEM-to-WB handshake: valid/bus from the memory stage, allowin back from write-back.
interface wb_stage_if;
    logic         ms_to_ws_valid;
    logic [154:0] ms_to_ws_bus;
    logic         ws_allowin;

    modport master (output ms_to_ws_valid, output ms_to_ws_bus, input ws_allowin);
    modport slave  (input ms_to_ws_valid, input ms_to_ws_bus, output ws_allowin);
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: retires one instruction per cycle, writes the register file,
// hosts the CP0 subset and commits exceptions/ERET as an upstream flush.
module wb_stage #(
    parameter logic [31:0] EX_ENTRY = 32'hbfc00380
) (
    input  logic         clk,
    input  logic         reset,
    wb_stage_if.slave    ms,
    output logic [40:0]  ws_to_rf_bus,
    output logic         ws_valid,
    output logic         ws_handle_ex,
    output logic [31:0]  ws_ex_target,
    output logic         ws_int_pending,
    output logic [31:0]  debug_wb_pc,
    output logic [3:0]   debug_wb_rf_wen,
    output logic [4:0]   debug_wb_rf_wnum,
    output logic [31:0]  debug_wb_rf_wdata
);
    localparam logic [7:0] AddrBadVAddr = 8'h40;
    localparam logic [7:0] AddrCount    = 8'h48;
    localparam logic [7:0] AddrCompare  = 8'h58;
    localparam logic [7:0] AddrStatus   = 8'h60;
    localparam logic [7:0] AddrCause    = 8'h68;
    localparam logic [7:0] AddrEpc      = 8'h70;

    logic         ws_valid_q;
    logic [154:0] bus_q;

    logic        ex, bd, eret, mtc0, res_from_cp0;
    logic [4:0]  exccode, dest;
    logic [31:0] badvaddr, cp0_wdata, final_result, pc;
    logic [7:0]  cp0_addr;
    logic [3:0]  bus_rf_we;

    assign ex           = bus_q[154];
    assign exccode      = bus_q[153:149];
    assign bd           = bus_q[148];
    assign badvaddr     = bus_q[147:116];
    assign eret         = bus_q[115];
    assign mtc0         = bus_q[114];
    assign cp0_addr     = bus_q[113:106];
    assign cp0_wdata    = bus_q[105:74];
    assign res_from_cp0 = bus_q[73];
    assign bus_rf_we    = bus_q[72:69];
    assign dest         = bus_q[68:64];
    assign final_result = bus_q[63:32];
    assign pc           = bus_q[31:0];

    assign ms.ws_allowin = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid_q <= 1'b0;
            bus_q      <= '0;
        end else begin
            // A committing exception/ERET squashes the instruction arriving behind it.
            ws_valid_q <= ms.ms_to_ws_valid && !ws_handle_ex;
            if (ms.ms_to_ws_valid && ms.ws_allowin) begin
                bus_q <= ms.ms_to_ws_bus;
            end
        end
    end

    logic commit_ex, commit_eret, commit_mtc0;
    assign commit_ex   = ws_valid_q && ex;
    assign commit_eret = ws_valid_q && eret && !ex;
    assign commit_mtc0 = ws_valid_q && mtc0 && !ex;

    logic [7:0]  status_im_q;
    logic        status_exl_q, status_ie_q;
    logic        cause_bd_q, cause_ti_q;
    logic [1:0]  cause_ip_q;
    logic [4:0]  cause_exccode_q;
    logic [31:0] epc_q, badvaddr_q, count_q, compare_q;
    logic        tick_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            status_im_q     <= '0;
            status_exl_q    <= 1'b0;
            status_ie_q     <= 1'b0;
            cause_bd_q      <= 1'b0;
            cause_ti_q      <= 1'b0;
            cause_ip_q      <= '0;
            cause_exccode_q <= '0;
            epc_q           <= '0;
            badvaddr_q      <= '0;
            count_q         <= '0;
            compare_q       <= '0;
            tick_q          <= 1'b0;
        end else begin
            tick_q <= ~tick_q;
            if (commit_mtc0 && cp0_addr == AddrCount) begin
                count_q <= cp0_wdata;
            end else if (tick_q) begin
                count_q <= count_q + 32'd1;
            end
            if (commit_mtc0 && cp0_addr == AddrCompare) begin
                compare_q  <= cp0_wdata;
                cause_ti_q <= 1'b0;
            end else if (count_q == compare_q) begin
                cause_ti_q <= 1'b1;
            end
            if (commit_mtc0 && cp0_addr == AddrStatus) begin
                status_im_q  <= cp0_wdata[15:8];
                status_exl_q <= cp0_wdata[1];
                status_ie_q  <= cp0_wdata[0];
            end
            if (commit_mtc0 && cp0_addr == AddrCause) begin
                cause_ip_q <= cp0_wdata[9:8];
            end
            if (commit_mtc0 && cp0_addr == AddrEpc) begin
                epc_q <= cp0_wdata;
            end
            if (commit_eret) begin
                status_exl_q <= 1'b0;
            end
            if (commit_ex) begin
                status_exl_q    <= 1'b1;
                cause_exccode_q <= exccode;
                // Nested exceptions keep the original return point.
                if (!status_exl_q) begin
                    epc_q      <= bd ? pc - 32'd4 : pc;
                    cause_bd_q <= bd;
                end
                if (exccode == 5'h04 || exccode == 5'h05) begin
                    badvaddr_q <= badvaddr;
                end
            end
        end
    end

    logic [31:0] status_word, cause_word, cp0_rdata, rf_wdata;
    logic [3:0]  rf_we;

    assign status_word = {9'b0, 1'b1, 6'b0, status_im_q, 6'b0, status_exl_q, status_ie_q};
    assign cause_word  = {cause_bd_q, cause_ti_q, 14'b0, cause_ti_q, 5'b0, cause_ip_q,
                          1'b0, cause_exccode_q, 2'b0};

    always_comb begin
        cp0_rdata = '0;
        unique case (cp0_addr)
            AddrBadVAddr: cp0_rdata = badvaddr_q;
            AddrCount:    cp0_rdata = count_q;
            AddrCompare:  cp0_rdata = compare_q;
            AddrStatus:   cp0_rdata = status_word;
            AddrCause:    cp0_rdata = cause_word;
            AddrEpc:      cp0_rdata = epc_q;
            default:      cp0_rdata = '0;
        endcase
    end

    assign rf_we    = (ws_valid_q && !ex) ? bus_rf_we : 4'b0;
    assign rf_wdata = res_from_cp0 ? cp0_rdata : final_result;

    assign ws_to_rf_bus      = {rf_we, dest, rf_wdata};
    assign ws_valid          = ws_valid_q;
    assign ws_handle_ex      = ws_valid_q && (ex || eret);
    assign ws_ex_target      = (eret && !ex) ? epc_q : EX_ENTRY;
    assign ws_int_pending    = status_ie_q && !status_exl_q &&
                               |(status_im_q & cause_word[15:8]);
    assign debug_wb_pc       = pc;
    assign debug_wb_rf_wen   = rf_we;
    assign debug_wb_rf_wnum  = dest;
    assign debug_wb_rf_wdata = rf_wdata;
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed instruction stream, word-level CP0 model checked every cycle,
// plus literal expectations at key points.
module tb_wb_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_stage_if bus_if ();

    logic [40:0] ws_to_rf_bus;
    logic        ws_valid, ws_handle_ex, ws_int_pending;
    logic [31:0] ws_ex_target, debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;

    wb_stage #(.EX_ENTRY(32'hbfc00380)) dut (
        .clk               (clk),
        .reset             (reset),
        .ms                (bus_if),
        .ws_to_rf_bus      (ws_to_rf_bus),
        .ws_valid          (ws_valid),
        .ws_handle_ex      (ws_handle_ex),
        .ws_ex_target      (ws_ex_target),
        .ws_int_pending    (ws_int_pending),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [154:0] mk(
        input logic ex, input logic [4:0] code, input logic bd, input logic [31:0] badv,
        input logic eret, input logic mtc0, input logic [7:0] addr, input logic [31:0] cwd,
        input logic rfc0, input logic [3:0] we, input logic [4:0] dest,
        input logic [31:0] res, input logic [31:0] pc);
        return {ex, code, bd, badv, eret, mtc0, addr, cwd, rfc0, we, dest, res, pc};
    endfunction

    function automatic logic [154:0] alu(input logic [4:0] d, input logic [31:0] r,
                                         input logic [31:0] pc);
        return mk(0, 5'd0, 0, 32'd0, 0, 0, 8'd0, 32'd0, 0, 4'hf, d, r, pc);
    endfunction
    function automatic logic [154:0] mfc0(input logic [7:0] a, input logic [4:0] d);
        return mk(0, 5'd0, 0, 32'd0, 0, 0, a, 32'd0, 1, 4'hf, d, 32'hdead0000, 32'h1000);
    endfunction
    function automatic logic [154:0] mtc0(input logic [7:0] a, input logic [31:0] w);
        return mk(0, 5'd0, 0, 32'd0, 0, 1, a, w, 0, 4'h0, 5'd0, 32'd0, 32'h2000);
    endfunction
    function automatic logic [154:0] exc(input logic [4:0] c, input logic bd,
                                         input logic [31:0] bv, input logic [31:0] pc);
        return mk(1, c, bd, bv, 0, 0, 8'd0, 32'd0, 0, 4'hf, 5'd6, 32'h55, pc);
    endfunction

    // Word-level model of the architectural state.
    logic         m_valid;
    logic [154:0] m_bus;
    logic [31:0]  m_status, m_cause, m_epc, m_badv, m_count, m_compare;
    logic         m_tick;

    function automatic logic [31:0] cause_rd();
        return m_cause | (m_cause[30] ? 32'h0000_8000 : 32'h0);
    endfunction

    function automatic logic [31:0] cp0_rd(input logic [7:0] a);
        case (a)
            8'h40:   return m_badv;
            8'h48:   return m_count;
            8'h58:   return m_compare;
            8'h60:   return m_status;
            8'h68:   return cause_rd();
            8'h70:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [154:0] b     = m_bus;
        logic         go    = m_valid;
        logic         ex    = b[154];
        logic [4:0]   code  = b[153:149];
        logic [7:0]   a     = b[113:106];
        logic [31:0]  cw    = b[105:74];
        logic [31:0]  pc    = b[31:0];
        logic         wr    = go && !ex && b[114];
        logic         hx    = go && (ex || b[115]);
        logic         exl0  = m_status[1];
        logic         hit   = (m_count == m_compare);
        if (wr && a == 8'h58) begin
            m_compare  = cw;
            m_cause[30] = 1'b0;
        end else if (hit) begin
            m_cause[30] = 1'b1;
        end
        if (wr && a == 8'h48) m_count = cw;
        else                  m_count = m_count + (m_tick ? 32'd1 : 32'd0);
        m_tick = ~m_tick;
        if (wr && a == 8'h60) m_status = (m_status & ~32'h0000ff03) | (cw & 32'h0000ff03);
        if (wr && a == 8'h68) m_cause  = (m_cause & ~32'h00000300) | (cw & 32'h00000300);
        if (wr && a == 8'h70) m_epc    = cw;
        if (go && b[115] && !ex) m_status[1] = 1'b0;
        if (go && ex) begin
            m_status[1]  = 1'b1;
            m_cause[6:2] = code;
            if (!exl0) begin
                m_epc       = b[148] ? pc - 32'd4 : pc;
                m_cause[31] = b[148];
            end
            if (code == 5'h04 || code == 5'h05) m_badv = b[147:116];
        end
        m_valid = bus_if.ms_to_ws_valid && !hx;
        if (bus_if.ms_to_ws_valid) m_bus = bus_if.ms_to_ws_bus;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_valid   = 1'b0;
            m_bus     = '0;
            m_status  = 32'h0040_0000;
            m_cause   = 32'h0;
            m_epc     = 32'h0;
            m_badv    = 32'h0;
            m_count   = 32'h0;
            m_compare = 32'h0;
            m_tick    = 1'b0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] cr, wd, tgt;
            logic [3:0]  we;
            logic        ex, ip;
            ex  = m_bus[154];
            cr  = cause_rd();
            we  = (m_valid && !ex) ? m_bus[72:69] : 4'h0;
            wd  = m_bus[73] ? cp0_rd(m_bus[113:106]) : m_bus[63:32];
            tgt = (m_bus[115] && !ex) ? m_epc : 32'hbfc00380;
            ip  = m_status[0] && !m_status[1] && |(m_status[15:8] & cr[15:8]);
            chk("ws_valid", ws_valid, m_valid);
            chk("ws_allowin", bus_if.ws_allowin, 1'b1);
            chk("ws_to_rf_bus", ws_to_rf_bus, {we, m_bus[68:64], wd});
            chk("ws_handle_ex", ws_handle_ex, m_valid && (ex || m_bus[115]));
            chk("ws_ex_target", ws_ex_target, tgt);
            chk("ws_int_pending", ws_int_pending, ip);
            chk("debug_wb_pc", debug_wb_pc, m_bus[31:0]);
            chk("debug_wb_rf_wen", debug_wb_rf_wen, we);
            chk("debug_wb_rf_wnum", debug_wb_rf_wnum, m_bus[68:64]);
            chk("debug_wb_rf_wdata", debug_wb_rf_wdata, wd);
        end
    end

    // Present an input for one cycle; on return the instruction sits in WB.
    task automatic cyc(input logic v, input logic [154:0] b);
        bus_if.ms_to_ws_valid = v;
        bus_if.ms_to_ws_bus   = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus_if.ms_to_ws_valid = 1'b0;
        bus_if.ms_to_ws_bus   = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_target", ws_ex_target, 32'hbfc00380);
        chk("rst_allowin", bus_if.ws_allowin, 1'b1);
        chk("rst_rf_bus", ws_to_rf_bus, 41'd0);
        reset = 1'b0;

        cyc(1, alu(5'd5, 32'h1234, 32'hbfc00000));
        chk("alu_rf_bus", ws_to_rf_bus, {4'hf, 5'd5, 32'h1234});
        chk("alu_pc", debug_wb_pc, 32'hbfc00000);

        cyc(1, exc(5'h04, 1'b1, 32'h3, 32'hbfc00104));
        chk("exc_handle", ws_handle_ex, 1'b1);
        chk("exc_wen", debug_wb_rf_wen, 4'h0);
        chk("exc_target", ws_ex_target, 32'hbfc00380);
        cyc(1, alu(5'd7, 32'h77, 32'hbfc00380));
        chk("exc_squash", ws_valid, 1'b0);
        cyc(1, mfc0(8'h70, 5'd2));
        chk("epc_dslot", debug_wb_rf_wdata, 32'hbfc00100);
        cyc(1, mfc0(8'h68, 5'd2));
        chk("cause_exc", debug_wb_rf_wdata, 32'hc0008010);
        cyc(1, mfc0(8'h40, 5'd2));
        chk("badvaddr", debug_wb_rf_wdata, 32'h3);
        cyc(1, mfc0(8'h60, 5'd2));
        chk("status_exl", debug_wb_rf_wdata, 32'h00400002);

        cyc(1, exc(5'h0a, 1'b0, 32'h0, 32'h100));
        cyc(0, '0);
        cyc(1, mfc0(8'h70, 5'd3));
        chk("nested_epc", debug_wb_rf_wdata, 32'hbfc00100);
        cyc(1, mfc0(8'h68, 5'd3));
        chk("nested_cause", debug_wb_rf_wdata, 32'hc0008028);

        cyc(1, mtc0(8'h70, 32'h80));
        cyc(1, mfc0(8'h70, 5'd4));
        chk("mfc0_epc", debug_wb_rf_wdata, 32'h80);
        cyc(1, mk(0, 5'd0, 0, 32'd0, 1, 0, 8'd0, 32'd0, 0, 4'h0, 5'd0, 32'd0, 32'h3000));
        chk("eret_handle", ws_handle_ex, 1'b1);
        chk("eret_target", ws_ex_target, 32'h80);
        cyc(0, '0);
        chk("eret_squash", ws_valid, 1'b0);
        cyc(1, mfc0(8'h60, 5'd4));
        chk("eret_status", debug_wb_rf_wdata, 32'h00400000);

        cyc(1, mtc0(8'h58, 32'd3));
        cyc(1, mtc0(8'h48, 32'd0));
        cyc(1, mfc0(8'h68, 5'd8));
        chk("ti_cleared", debug_wb_rf_wdata, 32'h80000028);
        for (int i = 0; i < 10; i++) cyc(0, '0);
        cyc(1, mfc0(8'h68, 5'd8));
        chk("ti_set", debug_wb_rf_wdata, 32'hc0008028);
        cyc(1, mtc0(8'h60, 32'h8001));
        cyc(0, '0);
        chk("int_pending_on", ws_int_pending, 1'b1);
        cyc(1, mtc0(8'h58, 32'd100));
        cyc(0, '0);
        chk("int_pending_off", ws_int_pending, 1'b0);

        cyc(1, exc(5'h00, 1'b0, 32'h0, 32'h200));
        cyc(1, alu(5'd9, 32'h99, 32'h204));
        cyc(1, alu(5'd9, 32'h99, 32'hbfc00380));
        chk("pre_reset_valid", ws_valid, 1'b1);
        reset = 1'b1;
        cyc(1, alu(5'd9, 32'h99, 32'hbfc00384));
        chk("mid_reset_valid", ws_valid, 1'b0);
        chk("mid_reset_wen", debug_wb_rf_wen, 4'h0);
        reset = 1'b0;
        cyc(1, mfc0(8'h48, 5'd10));
        chk("reset_count", debug_wb_rf_wdata, 32'h0);
        cyc(1, mfc0(8'h60, 5'd10));
        chk("reset_status", debug_wb_rf_wdata, 32'h00400000);
        cyc(0, '0);
        cyc(0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
